edusoc_membus_arbiter: RTL

- N-master to 1-slave arbiter for the SoC memory bus (req/valid, addr, write_en, byte_en, write_data, read_data).
- Lets several requestors share one SoC bus slave port, e.g. a second core, a DMA engine or a debug port sharing the data bus.
- All ports are flattened vectors, so the block is Verilog-compatible and sits between the requestors and the SoC slave.
- Supports selectable arbitration policy and a bus-timeout abort with error reporting.

---
 rtl/edusoc_membus_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/edusoc_membus_arbiter.sv
// N-master to 1-slave memory bus arbiter with fixed-priority or round-robin grant,
// registered slave-side request, and a bus-timeout abort that answers the owner itself.
module edusoc_membus_arbiter #(
  parameter int          NUM_MASTERS    = 2,
  parameter int          ARB_MODE       = 1,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
  localparam int         ID_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      resn,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [4*NUM_MASTERS-1:0]  m_be,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_valid,
  output logic [32*NUM_MASTERS-1:0] m_rdata,
  output logic                      s_req,
  output logic [31:0]               s_addr,
  output logic                      s_we,
  output logic [3:0]                s_be,
  output logic [31:0]               s_wdata,
  input  logic                      s_valid,
  input  logic [31:0]               s_rdata,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int             CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  rr_ptr, ptr_next, winner;
  logic [CNT_W-1:0] counter;
  logic             timeout_hit, done;
  int               idx;

  // Winner search: later loop iterations override earlier ones, so iterate from the
  // least-preferred candidate down to the most-preferred.
  always_comb begin
    winner = '0;
    idx    = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (m_req[i]) winner = ID_W'(i);
      end
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (m_req[idx]) winner = ID_W'(idx);
      end
    end
  end

  assign ptr_next    = (grant_id == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (counter == CNT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, otherwise latches are inferred.
  always_comb begin
    state_next  = state;
    s_req       = 1'b0;
    busy        = 1'b0;
    m_valid     = '0;
    m_rdata     = '0;
    timeout_err = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (|m_req) state_next = BUSY;
      BUSY: begin
        s_req = 1'b1;
        busy  = 1'b1;
        // A real response takes precedence over an abort landing in the same cycle.
        if (s_valid) begin
          done                          = 1'b1;
          m_valid[grant_id]             = 1'b1;
          m_rdata[32*grant_id +: 32]    = s_rdata;
          state_next                    = IDLE;
        end else if (timeout_hit) begin
          done                          = 1'b1;
          m_valid[grant_id]             = 1'b1;
          m_rdata[32*grant_id +: 32]    = TIMEOUT_DATA;
          timeout_err                   = 1'b1;
          state_next                    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave-side request fields are captured once at grant and held for the whole transfer.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      s_addr   <= '0;
      s_we     <= 1'b0;
      s_be     <= '0;
      s_wdata  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      counter  <= '0;
    end else begin
      case (state)
        IDLE: if (|m_req) begin
          s_addr   <= m_addr[32*winner +: 32];
          s_we     <= m_we[winner];
          s_be     <= m_be[4*winner +: 4];
          s_wdata  <= m_wdata[32*winner +: 32];
          grant_id <= winner;
          counter  <= CNT_W'(1);
        end
        BUSY: begin
          if (done)                    rr_ptr  <= ptr_next;
          else if (counter != CNT_MAX) counter <= counter + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
